// File: rtl/sens_bus_pkg.sv
// Shared types and default widths for the sensor bus monitor.
package sens_bus_pkg;

  localparam int unsigned SENS_H_W   = 16;
  localparam int unsigned SENS_V_W   = 16;
  localparam int unsigned SENS_PIX_W = 14;
  localparam int unsigned SENS_LANES = 4;
  localparam int unsigned SENS_SUM_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mon_state_t;

  typedef struct packed {
    logic                                    h_start;
    logic                                    v_start;
    logic                                    h_blank;
    logic                                    v_blank;
    logic [SENS_LANES-1:0][SENS_PIX_W-1:0]   pix_data;
  } sens_bus_t;

  typedef struct packed {
    logic [SENS_H_W-1:0]   h_total;
    logic [SENS_H_W-1:0]   h_active;
    logic [SENS_V_W-1:0]   v_total;
    logic [SENS_V_W-1:0]   v_active;
    logic [SENS_SUM_W-1:0] pix_sum;
    logic [15:0]           frame_cnt;
  } meas_t;

endpackage

// File: rtl/sens_line_meas.sv
// Per-line cycle and active-beat counting with in-frame reference compare.
module sens_line_meas #(
  parameter int unsigned H_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           line_start,
  input  logic           frame_start,
  input  logic           active,
  output logic [H_W-1:0] line_len,
  output logic [H_W-1:0] line_act,
  output logic [H_W-1:0] act_last,
  output logic           hlen_mis,
  output logic           hact_mis,
  output logic           ovf
);

  logic [H_W-1:0] hc;
  logic [H_W-1:0] bc;
  logic [H_W-1:0] h_ref;
  logic [H_W-1:0] a_ref;
  logic [H_W-1:0] last_act;
  logic           h_ref_vld;
  logic           a_ref_vld;
  logic           close;

  // A line only closes while running; the start edge from idle just opens one.
  assign close    = run & line_start;
  assign line_len = hc;
  assign line_act = bc;
  assign act_last = (bc != '0) ? bc : last_act;
  assign hlen_mis = close & h_ref_vld & (hc != h_ref);
  assign hact_mis = close & (bc != '0) & a_ref_vld & (bc != a_ref);
  assign ovf      = run & ~line_start & ((hc == '1) | (active & (bc == '1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc        <= '0;
      bc        <= '0;
      h_ref     <= '0;
      a_ref     <= '0;
      last_act  <= '0;
      h_ref_vld <= 1'b0;
      a_ref_vld <= 1'b0;
    end else begin
      if (line_start) begin
        hc <= H_W'(1);
        bc <= H_W'(active);
      end else if (run) begin
        if (hc != '1) hc <= hc + H_W'(1);
        if (active && bc != '1) bc <= bc + H_W'(1);
      end

      if (close) begin
        if (!h_ref_vld) begin
          h_ref     <= hc;
          h_ref_vld <= 1'b1;
        end
        if (bc != '0) begin
          last_act <= bc;
          if (!a_ref_vld) begin
            a_ref     <= bc;
            a_ref_vld <= 1'b1;
          end
        end
      end

      // Closing compares above used the old references; frame start drops them.
      if (frame_start) begin
        h_ref_vld <= 1'b0;
        a_ref_vld <= 1'b0;
        last_act  <= '0;
      end
    end
  end

endmodule

// File: rtl/sens_bus_mon.sv
// Sensor bus receive monitor: per-frame timing, checksum and sticky protocol errors.
module sens_bus_mon
  import sens_bus_pkg::*;
#(
  parameter int unsigned H_W   = SENS_H_W,
  parameter int unsigned V_W   = SENS_V_W,
  parameter int unsigned PIX_W = SENS_PIX_W,
  parameter int unsigned LANES = SENS_LANES,
  parameter int unsigned SUM_W = SENS_SUM_W
) (
  input  logic                        clk_72m,
  input  logic                        xreset,
  input  logic                        sens_h_start,
  input  logic                        sens_v_start,
  input  logic                        sens_h_blank,
  input  logic                        sens_v_blank,
  input  logic [LANES-1:0][PIX_W-1:0] sens_pix_data,
  input  logic                        err_clr,
  output logic                        meas_valid,
  output logic [H_W-1:0]              h_total,
  output logic [H_W-1:0]              h_active,
  output logic [V_W-1:0]              v_total,
  output logic [V_W-1:0]              v_active,
  output logic [SUM_W-1:0]            pix_sum,
  output logic [15:0]                 frame_cnt,
  output logic                        err_sync,
  output logic                        err_hlen,
  output logic                        err_hact,
  output logic                        err_ovf
);

  mon_state_t     state;
  logic           in_run;
  logic           active;
  logic           line_start;
  logic           lc_sat;
  logic           alc_sat;
  logic           sync_set;
  logic [V_W-1:0] lc;
  logic [V_W-1:0] alc;
  logic [V_W-1:0] alc_next;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] beat_sum;
  logic [SUM_W-1:0] beat_add;
  logic [H_W-1:0] line_len;
  logic [H_W-1:0] line_act;
  logic [H_W-1:0] act_last;
  logic           hlen_mis;
  logic           hact_mis;
  logic           line_ovf;

  assign in_run     = (state == ST_RUN);
  assign active     = ~sens_h_blank & ~sens_v_blank;
  // v_start alone still opens a new line so the frame restarts cleanly.
  assign line_start = sens_v_start | (sens_h_start & in_run);
  assign sync_set   = sens_v_start & ~sens_h_start;
  assign lc_sat     = in_run & ~sens_v_start & sens_h_start & (lc == '1);
  assign alc_sat    = in_run & line_start & (line_act != '0) & (alc == '1);
  assign alc_next   = ((line_act != '0) && (alc != '1)) ? alc + V_W'(1) : alc;
  assign beat_add   = active ? beat_sum : '0;

  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + SUM_W'(sens_pix_data[i]);
    end
  end

  sens_line_meas #(
    .H_W (H_W)
  ) u_line_meas (
    .clk         (clk_72m),
    .rst_n       (xreset),
    .run         (in_run),
    .line_start  (line_start),
    .frame_start (sens_v_start),
    .active      (active),
    .line_len    (line_len),
    .line_act    (line_act),
    .act_last    (act_last),
    .hlen_mis    (hlen_mis),
    .hact_mis    (hact_mis),
    .ovf         (line_ovf)
  );

  always_ff @(posedge clk_72m or negedge xreset) begin
    if (!xreset) begin
      state      <= ST_IDLE;
      meas_valid <= 1'b0;
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      pix_sum    <= '0;
      frame_cnt  <= '0;
      lc         <= '0;
      alc        <= '0;
      acc        <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sens_v_start) begin
            state <= ST_RUN;
            lc    <= V_W'(1);
            alc   <= '0;
            acc   <= beat_add;
          end
        end
        ST_RUN: begin
          if (sens_v_start) begin
            h_total    <= line_len;
            h_active   <= act_last;
            v_total    <= lc;
            v_active   <= alc_next;
            pix_sum    <= acc;
            frame_cnt  <= frame_cnt + 16'd1;
            meas_valid <= 1'b1;
            lc         <= V_W'(1);
            alc        <= '0;
            acc        <= beat_add;
          end else begin
            if (sens_h_start) begin
              if (lc != '1) lc <= lc + V_W'(1);
              alc <= alc_next;
            end
            acc <= acc + beat_add;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_72m or negedge xreset) begin
    if (!xreset) begin
      err_sync <= 1'b0;
      err_hlen <= 1'b0;
      err_hact <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      err_sync <= sync_set | (err_sync & ~err_clr);
      err_hlen <= hlen_mis | (err_hlen & ~err_clr);
      err_hact <= hact_mis | (err_hact & ~err_clr);
      err_ovf  <= line_ovf | lc_sat | alc_sat | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sens_bus_mon.sv
// Directed and randomized frame stream against a frame-level reference model.
module tb_sens_bus_mon;
  import sens_bus_pkg::*;

  logic clk_72m = 1'b0;
  always #5 clk_72m = ~clk_72m;

  logic        xreset;
  logic        err_clr;
  sens_bus_t   bus;
  logic        meas_valid;
  logic [15:0] h_total, h_active, v_total, v_active, frame_cnt;
  logic [31:0] pix_sum;
  logic        err_sync, err_hlen, err_hact, err_ovf;

  sens_bus_mon #(
    .H_W   (16),
    .V_W   (16),
    .PIX_W (14),
    .LANES (4),
    .SUM_W (32)
  ) dut (
    .clk_72m       (clk_72m),
    .xreset        (xreset),
    .sens_h_start  (bus.h_start),
    .sens_v_start  (bus.v_start),
    .sens_h_blank  (bus.h_blank),
    .sens_v_blank  (bus.v_blank),
    .sens_pix_data (bus.pix_data),
    .err_clr       (err_clr),
    .meas_valid    (meas_valid),
    .h_total       (h_total),
    .h_active      (h_active),
    .v_total       (v_total),
    .v_active      (v_active),
    .pix_sum       (pix_sum),
    .frame_cnt     (frame_cnt),
    .err_sync      (err_sync),
    .err_hlen      (err_hlen),
    .err_hact      (err_hact),
    .err_ovf       (err_ovf)
  );

  int total = 0;
  int bad = 0;
  int mv_seen = 0;
  always @(negedge clk_72m) if (meas_valid === 1'b1) mv_seen++;

  // Reference model state: expected measurements of the last frame sent,
  // sticky flags, and errors that only show when that frame's last line closes.
  int ll[16];
  int lb[16];
  int e_ht, e_ha, e_vt, e_va, e_fc, e_mv;
  logic [31:0] e_pix;
  bit pend, p_hlen, p_hact;
  bit e_sync, e_hlen, e_hact, e_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_72m);
    #1;
  endtask

  function automatic int cap(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic set_lines(input int n, input int len, input int blk);
    for (int i = 0; i < n; i++) begin
      ll[i] = len;
      lb[i] = blk;
    end
  endtask

  task automatic clear_flags();
    e_sync = 0; e_hlen = 0; e_hact = 0; e_ovf = 0;
  endtask

  task automatic chk_flags();
    chk("err_sync", err_sync, e_sync);
    chk("err_hlen", err_hlen, e_hlen);
    chk("err_hact", err_hact, e_hact);
    chk("err_ovf", err_ovf, e_ovf);
  endtask

  task automatic chk_zero();
    chk("rst_mv", meas_valid, 0);
    chk("rst_h_total", h_total, 0);
    chk("rst_h_active", h_active, 0);
    chk("rst_v_total", v_total, 0);
    chk("rst_v_active", v_active, 0);
    chk("rst_pix_sum", pix_sum, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_sync", err_sync, 0);
    chk("rst_err_hlen", err_hlen, 0);
    chk("rst_err_hact", err_hact, 0);
    chk("rst_err_ovf", err_ovf, 0);
  endtask

  task automatic check_close();
    if (pend) begin
      e_fc++;
      e_mv++;
      chk("mv", meas_valid, 1);
      chk("h_total", h_total, e_ht);
      chk("h_active", h_active, e_ha);
      chk("v_total", v_total, e_vt);
      chk("v_active", v_active, e_va);
      chk("pix_sum", pix_sum, e_pix);
      chk("frame_cnt", frame_cnt, e_fc);
    end else begin
      chk("mv_first", meas_valid, 0);
    end
    chk_flags();
  endtask

  // pmode: 0 all ones, 1 all full-scale, 2 random
  task automatic send_frame(input int nl, input int nvbl, input int pmode, input bit no_hs,
                            input bit clr_vs, input bit clr_l1, input int stop_after);
    int act, ref_act, alc, last_act, cyc, len, ref_len;
    logic [31:0] fsum;
    bit eh, ea, lh, la, ov, bh, ba, is_act;
    ref_act = -1; alc = 0; last_act = 0; cyc = 0; len = 0;
    fsum = '0; eh = 0; ea = 0; lh = 0; la = 0; ov = 0;
    ref_len = cap(ll[0]);
    for (int l = 0; l < nl; l++) begin
      act = 0;
      for (int c = 0; c < ll[l]; c++) begin
        bus.v_start = (l == 0 && c == 0);
        bus.h_start = (c == 0) && !(l == 0 && no_hs);
        bus.v_blank = (l < nvbl);
        bus.h_blank = (c < lb[l]);
        err_clr = (l == 0 && c == 0 && clr_vs) || (l == 1 && c == 0 && clr_l1);
        for (int k = 0; k < 4; k++)
          bus.pix_data[k] = (pmode == 0) ? 14'd1 : (pmode == 1) ? 14'd16383 : 14'($urandom_range(0, 16383));
        is_act = !bus.h_blank && !bus.v_blank;
        if (is_act) begin
          act++;
          for (int k = 0; k < 4; k++) fsum = fsum + 32'(bus.pix_data[k]);
        end
        step();
        cyc++;
        if (l == 0 && c == 0) begin
          if (clr_vs) clear_flags();
          if (pend) begin
            e_hlen |= p_hlen;
            e_hact |= p_hact;
          end
          if (no_hs) e_sync = 1;
          check_close();
          pend = 0;
        end
        if (l == 0 && c == 1) chk("mv_one_cycle", meas_valid, 0);
        if (l == 1 && c == 0 && clr_l1) begin
          clear_flags();
          chk_flags();
        end
        if (stop_after == cyc) begin
          err_clr = 0;
          return;
        end
      end
      err_clr = 0;
      len = cap(ll[l]);
      bh = (l > 0) && (len != ref_len);
      ba = 0;
      if (act > 0) begin
        if (ref_act < 0) ref_act = act;
        else ba = (act != ref_act);
        alc++;
        last_act = act;
      end
      if (l < nl - 1) begin
        eh |= bh;
        ea |= ba;
      end else begin
        lh = bh;
        la = ba;
      end
      if (ll[l] > 65535) ov = 1;
    end
    e_hlen |= eh; e_hact |= ea; e_ovf |= ov;
    p_hlen = lh; p_hact = la; pend = 1;
    e_ht = len; e_ha = last_act; e_vt = nl; e_va = alc; e_pix = fsum;
    chk_flags();
  endtask

  initial begin
    int nl, len, li;
    xreset = 1'b0;
    err_clr = 1'b0;
    bus = '0;
    pend = 0; p_hlen = 0; p_hact = 0; e_fc = 0; e_mv = 0;
    clear_flags();
    repeat (3) step();
    chk_zero();
    xreset = 1'b1;
    step();

    // nominal stream: 100-cycle lines, 20 blank, 10 lines, 2 v-blank lines
    set_lines(10, 100, 20);
    repeat (3) send_frame(10, 2, 0, 0, 0, 0, 0);
    chk("t1_pulses", mv_seen, 2);
    chk("t1_h_total", h_total, 100);
    chk("t1_h_active", h_active, 80);
    chk("t1_v_total", v_total, 10);
    chk("t1_v_active", v_active, 8);
    chk("t1_pix_sum", pix_sum, 2560);
    chk("t1_frame_cnt", frame_cnt, 2);

    // one 101-cycle line (active width unchanged), then err_clr
    set_lines(10, 100, 20);
    ll[5] = 101; lb[5] = 21;
    send_frame(10, 2, 0, 0, 0, 0, 0);
    chk("t2_hlen_set", err_hlen, 1);
    chk("t2_hact_clear", err_hact, 0);
    set_lines(10, 100, 20);
    send_frame(10, 2, 0, 0, 0, 1, 0);
    chk("t2_hlen_cleared", err_hlen, 0);

    // v_start without h_start, with err_clr in the same cycle
    set_lines(4, 30, 10);
    send_frame(4, 0, 2, 1, 1, 0, 0);
    chk("t3_sync_wins", err_sync, 1);
    set_lines(3, 20, 5);
    send_frame(3, 0, 2, 0, 0, 0, 0);
    chk("t3_v_total", v_total, 4);

    // full-scale pixels
    set_lines(10, 100, 20);
    send_frame(10, 2, 1, 0, 0, 0, 0);
    set_lines(3, 20, 5);
    send_frame(3, 1, 2, 0, 0, 0, 0);
    chk("t4_pix_max", pix_sum, 41940480);

    // randomized frames, occasional odd line
    for (int r = 0; r < 6; r++) begin
      nl = $urandom_range(2, 6);
      len = $urandom_range(12, 40);
      set_lines(nl, len, $urandom_range(0, len));
      if ($urandom_range(0, 2) == 0) begin
        li = $urandom_range(1, nl - 1);
        ll[li] = len + $urandom_range(1, 3);
        lb[li] = $urandom_range(0, ll[li]);
      end
      send_frame(nl, $urandom_range(0, 1), 2, 0, 0, 0, 0);
    end

    // reset mid-frame
    set_lines(5, 20, 4);
    send_frame(5, 1, 2, 0, 0, 0, 37);
    xreset = 1'b0;
    #1;
    chk_zero();
    bus = '0;
    pend = 0; p_hlen = 0; p_hact = 0; e_fc = 0;
    clear_flags();
    step();
    step();
    xreset = 1'b1;
    send_frame(5, 1, 2, 0, 0, 0, 0);
    send_frame(5, 1, 2, 0, 0, 0, 0);
    chk("t5_frame_cnt", frame_cnt, 1);

    // 70000-cycle line saturates the 16-bit line counter
    set_lines(1, 70000, 70000);
    send_frame(1, 1, 0, 0, 0, 0, 0);
    chk("t6_ovf", err_ovf, 1);
    set_lines(2, 20, 5);
    send_frame(2, 0, 2, 0, 0, 0, 0);
    chk("t6_h_total_sat", h_total, 65535);

    bus = '0;
    step();
    step();
    chk("mv_count", mv_seen, e_mv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sens_bus_mon.md
Name: sens_bus_mon

Overview:
Receive-side counterpart of the sensor emulator. It samples the 4-lane sensor bus (h/v start pulses, h/v blank, pixel data) and measures frame timing per frame. Outputs are line length, active width, line counts and a pixel checksum, plus sticky protocol-error flags. It sits on the same bus as the NR/SR adder and serves as an in-design monitor and a bench scoreboard source.

Parameters:
H_W, 16, width of horizontal counters (cycles/beats per line)
V_W, 16, width of vertical counters (lines per frame)
PIX_W, 14, bits per pixel
LANES, 4, pixels per beat
SUM_W, 32, checksum width

Ports:
clk_72m  in  1  bus clock
xreset  in  1  asynchronous active-low reset
sens_h_start  in  1  one-cycle line-start pulse
sens_v_start  in  1  one-cycle frame-start pulse, must coincide with sens_h_start
sens_h_blank  in  1  high = horizontal blanking
sens_v_blank  in  1  high = vertical blanking
sens_pix_data  in  [LANES-1:0][PIX_W-1:0]  pixel lanes
err_clr  in  1  clears sticky error flags
meas_valid  out  1  one-cycle pulse: measurement outputs updated
h_total  out  H_W  cycles per line (last completed line)
h_active  out  H_W  active beats in last active line
v_total  out  V_W  lines per frame
v_active  out  V_W  lines containing ≥1 active beat
pix_sum  out  SUM_W  sum of all active pixels in frame, mod 2^SUM_W
frame_cnt  out  16  completed frames, wraps
err_sync  out  1  sticky: v_start without h_start
err_hlen  out  1  sticky: line length differs within frame
err_hact  out  1  sticky: active width differs between active lines in frame
err_ovf  out  1  sticky: any counter saturated

Behaviour:
- Active beat = !sens_h_blank && !sens_v_blank, sampled every cycle; the h_start cycle itself can be active.
- FSM, 2 states. IDLE: ignore everything until sens_v_start, then go to RUN and clear frame accumulators. RUN: accumulate. On each further sens_v_start, close the frame, then restart accumulators in the same cycle.
- Reset (any time, including mid-frame): state IDLE, all outputs 0, all counters 0.
- Horizontal: hc resets to 1 on h_start, else increments and saturates at all-ones. At saturation err_ovf sets.
  - On h_start, the previous line's hc is "line length" when a previous h_start exists in this frame.
  - The first line length of a frame is the reference. A later mismatch sets err_hlen.
- Active width: beat counter per line, closed at h_start. For closed lines with count>0, the first is the reference and a mismatch sets err_hact. The last nonzero count is held for h_active.
- Vertical: lc counts h_start pulses in the frame, including the one coincident with v_start. alc counts closed lines with beat count>0. Both saturate and set err_ovf.
- Checksum: each active beat adds the sum of all LANES pixels (zero-extended) to acc, mod 2^SUM_W.
- Frame close, on a sens_v_start edge while in RUN:
  - h_total, h_active, v_total, v_active and pix_sum are registered from the closing frame. The line ended by this v_start/h_start counts as closed.
  - frame_cnt increments.
  - meas_valid is high the cycle after the sampling edge, for exactly 1 cycle.
  - The first v_start, from IDLE, produces no meas_valid.
- sens_v_start without sens_h_start: err_sync sets. It is still treated as a frame start, with the line counter restarted at 1.
- Sticky errors persist until err_clr. If err_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- Error comparisons occurring at frame close use the closing frame's references. References then reset.
- Outputs keep their values between meas_valid pulses.

Decomposition:
- Shared package sens_bus_pkg holds:
  - sens_bus_t struct (h_start, v_start, h_blank, v_blank, pix_data)
  - default PIX_W/LANES constants
  - meas_t struct for the measurement outputs
- One sub-module is natural: sens_line_meas, which covers the per-line hc/beat counting, reference compare and saturation. The top holds the FSM, vertical counts, checksum and error registers.

Test Plan:
- Stimulus: line 100 cycles, h_blank first 20 cycles, 10 lines/frame, v_blank on lines 0-1, all pixels = 1, 3 frames. Required response: 2 meas_valid pulses with h_total=100, h_active=80, v_total=10, v_active=8, pix_sum=2560, frame_cnt=2, no errors.
- Stimulus: same stream with line 5 of frame 2 lengthened to 101 cycles. Required response: err_hlen=1 after frame 2 close; other flags 0; err_clr pulse returns it to 0.
- Stimulus: v_start pulse without h_start. Required response: err_sync=1 next cycle; v_total of the following frame counts from 1.
- Stimulus: pixels all 16383 on 4 lanes, 80 beats × 8 lines. Required response: pix_sum=4×16383×640=41,940,480.
- Stimulus: assert xreset low mid-frame, release, restart stream. Required response: all outputs 0 during reset; first post-reset v_start gives no meas_valid; second gives correct values.
- Stimulus: 70,000-cycle line with H_W=16. Required response: err_ovf=1 and h_total=65535.
